// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state enumeration and command codes for the SPI slave
// Purpose: one place for the FSM state type and the 2-bit frame command values.
// Ports: none (package).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    RD_WAIT,
    TX,
    HOLD
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - bidirectional-order serial shift register shared by rx and tx
// Purpose: holds the WIDTH-bit data field while it is shifted in from mosi or out to miso.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   load, din      parallel load (wins over shift)
//   shift, sin     shift one position, sin enters at the far end from the outgoing bit
//   q_nxt          register value after a shift with the current sin
//   sout_nxt       outgoing bit of q_nxt (the bit to drive after this shift)
//   din_head       outgoing bit of din (the first bit to drive after a load)
module spi_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt,
  output logic             din_head
);

  logic [WIDTH-1:0] q;

  // MSB-first: bits leave from the top and the first-received bit ends at the top.
  // LSB-first: bits leave from bit 0 and the first-received bit ends at bit 0.
  always_comb begin
    if (LSB_FIRST != 0) begin
      q_nxt    = {sin, q[WIDTH-1:1]};
      sout_nxt = q_nxt[0];
      din_head = din[0];
    end else begin
      q_nxt    = {q[WIDTH-2:0], sin};
      sout_nxt = q_nxt[WIDTH-1];
      din_head = din[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - clk-sampled SPI slave with 2-bit command frames and read-back
// Purpose: receives FRAME_W = WORD_W+2 bit frames on mosi; a CMD_RD_DATA frame waits
//          for tx_data from memory and returns it on miso.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   ss_n, mosi          slave select (active low) and serial input, sampled on clk
//   tx_valid, tx_data   read data handshake from memory (only used in RD_WAIT)
//   miso                registered serial output
//   rx_valid, rx_data   one-cycle frame-complete pulse and the frame {cmd, word}
//   busy                high whenever the FSM is not in IDLE
//   err                 one-cycle pulse on an aborted transaction
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int LSB_FIRST   = 0,
  parameter int RD_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss_n,
  input  logic                mosi,
  input  logic                tx_valid,
  input  logic [WORD_W-1:0]   tx_data,
  output logic                miso,
  output logic                rx_valid,
  output logic [WORD_W+1:0]   rx_data,
  output logic                busy,
  output logic                err
);

  localparam int FRAME_W = WORD_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WAIT_W  = $clog2(RD_WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]  RX_LAST   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  TX_LAST   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CMD_BITS  = CNT_W'(2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT_MAX - 1);

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [WAIT_W-1:0] wcnt;
  logic [1:0]        cmd;
  // Set once ss_n has been seen high after reset; a select held low through
  // reset must not start a frame.
  logic              armed;

  logic              cnt_clr, cnt_inc, wcnt_clr, wcnt_inc;
  logic              cap_cmd, sr_load, sr_shift, sr_sin;
  logic              rx_done, err_set, miso_nxt;
  logic [WORD_W-1:0] sr_q_nxt;
  logic              sr_sout_nxt, sr_din_head;

  spi_shift_reg #(
    .WIDTH     (WORD_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .din      (tx_data),
    .shift    (sr_shift),
    .sin      (sr_sin),
    .q_nxt    (sr_q_nxt),
    .sout_nxt (sr_sout_nxt),
    .din_head (sr_din_head)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wcnt_clr  = 1'b0;
    wcnt_inc  = 1'b0;
    cap_cmd   = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_sin    = 1'b0;
    rx_done   = 1'b0;
    err_set   = 1'b0;
    miso_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_n && armed) begin
          state_nxt = RX;
          cnt_clr   = 1'b1;
        end
      end
      RX: begin
        if (ss_n) begin
          // Deselect before the first bit is not an abort.
          state_nxt = IDLE;
          err_set   = (cnt != '0);
        end else begin
          cnt_inc = 1'b1;
          if (cnt < CMD_BITS) begin
            cap_cmd = 1'b1;
          end else begin
            sr_shift = 1'b1;
            sr_sin   = mosi;
          end
          if (cnt == RX_LAST) begin
            rx_done   = 1'b1;
            wcnt_clr  = 1'b1;
            state_nxt = (cmd == CMD_RD_DATA) ? RD_WAIT : HOLD;
          end
        end
      end
      RD_WAIT: begin
        wcnt_inc = 1'b1;
        if (ss_n) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (tx_valid) begin
          // cnt tracks bits already driven minus one; the head bit goes out now.
          sr_load   = 1'b1;
          miso_nxt  = sr_din_head;
          cnt_clr   = 1'b1;
          state_nxt = TX;
        end else if (wcnt == WAIT_LAST) begin
          state_nxt = HOLD;
          err_set   = 1'b1;
        end
      end
      TX: begin
        if (ss_n) begin
          state_nxt = IDLE;
          err_set   = 1'b1;
        end else if (cnt == TX_LAST) begin
          state_nxt = HOLD;
        end else begin
          sr_shift = 1'b1;
          miso_nxt = sr_sout_nxt;
          cnt_inc  = 1'b1;
        end
      end
      HOLD: begin
        if (ss_n) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wcnt     <= '0;
      cmd      <= '0;
      armed    <= 1'b0;
      miso     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      err      <= 1'b0;
    end else begin
      if (ss_n) begin
        armed <= 1'b1;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (wcnt_clr) begin
        wcnt <= '0;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + 1'b1;
      end
      if (cap_cmd) begin
        cmd <= {cmd[0], mosi};
      end
      if (rx_done) begin
        rx_data <= {cmd, sr_q_nxt};
      end
      miso     <= miso_nxt;
      rx_valid <= rx_done;
      err      <= err_set;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - self-checking bench for spi_slave_param
module tb_spi_slave_param;

  logic        clk;
  logic        rst;
  logic        ss_n, mosi, tx_valid;
  logic [7:0]  tx_data;
  logic        miso, rx_valid, busy, err;
  logic [9:0]  rx_data;

  logic        ss_n_l, mosi_l, tx_valid_l;
  logic [11:0] tx_data_l;
  logic        miso_l, rx_valid_l, busy_l, err_l;
  logic [13:0] rx_data_l;

  int total = 0;
  int bad   = 0;

  spi_slave_param dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .miso(miso), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .err(err)
  );

  spi_slave_param #(.WORD_W(12), .LSB_FIRST(1), .RD_WAIT_MAX(15)) dut_l (
    .clk(clk), .rst(rst), .ss_n(ss_n_l), .mosi(mosi_l),
    .tx_valid(tx_valid_l), .tx_data(tx_data_l),
    .miso(miso_l), .rx_valid(rx_valid_l), .rx_data(rx_data_l),
    .busy(busy_l), .err(err_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i as it appears on the wire: command MSB-first, then the word
  // in the configured order.
  function automatic logic fbit(input logic [1:0] c, input logic [31:0] word,
                                input int w, input bit lsb, input int i);
    if (i < 2) return c[1-i];
    return lsb ? word[i-2] : word[w-1-(i-2)];
  endfunction

  task automatic send_frame(input logic [1:0] c, input logic [7:0] word);
    ss_n = 1'b1;
    step();
    ss_n = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      mosi = fbit(c, {24'd0, word}, 8, 1'b0, i);
      step();
      chk("rx_valid_pulse", {31'd0, rx_valid}, {31'd0, (i == 9)});
      chk("rx_err", {31'd0, err}, 32'd0);
    end
    mosi = 1'b0;
  endtask

  task automatic send_frame_l(input logic [1:0] c, input logic [11:0] word);
    ss_n_l = 1'b1;
    step();
    ss_n_l = 1'b0;
    step();
    for (int i = 0; i < 14; i++) begin
      mosi_l = fbit(c, {20'd0, word}, 12, 1'b1, i);
      step();
      chk("lsb_rx_valid", {31'd0, rx_valid_l}, {31'd0, (i == 13)});
    end
    mosi_l = 1'b0;
    chk("lsb_rx_data", {18'd0, rx_data_l}, {18'd0, c, word});
    ss_n_l = 1'b1;
    step();
  endtask

  // In RD_WAIT: wait d cycles then offer data; d >= 15 must time out.
  task automatic read_back(input int d, input logic [7:0] data);
    if (d < 15) begin
      for (int k = 0; k < d; k++) begin
        step();
        chk("rd_wait_err", {31'd0, err}, 32'd0);
        chk("rd_wait_miso", {31'd0, miso}, 32'd0);
      end
      tx_valid = 1'b1;
      tx_data  = data;
      step();
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        chk("tx_bit", {31'd0, miso}, {31'd0, data[7-j]});
        chk("tx_err", {31'd0, err}, 32'd0);
        step();
      end
      chk("tx_end_miso", {31'd0, miso}, 32'd0);
      chk("tx_end_busy", {31'd0, busy}, 32'd1);
    end else begin
      tx_valid = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        step();
        chk("timeout_err", {31'd0, err}, {31'd0, (k == 15)});
        chk("timeout_miso", {31'd0, miso}, 32'd0);
      end
      step();
      chk("timeout_err_single", {31'd0, err}, 32'd0);
      chk("timeout_hold_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    logic [1:0] c;
    logic [7:0] w, td;
    int d;

    rst = 1'b1; ss_n = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    ss_n_l = 1'b0; mosi_l = 1'b0; tx_valid_l = 1'b0; tx_data_l = 12'h000;
    step(); step(); step();
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_start_after_rst", {31'd0, busy}, 32'd0);
    end

    // Write frame, then tx_valid offered in HOLD must be ignored.
    send_frame(2'b00, 8'hA5);
    chk("wr_rx_data", {22'd0, rx_data}, 32'h0A5);
    tx_valid = 1'b1; tx_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      mosi = 1'($urandom);
      step();
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_miso", {31'd0, miso}, 32'd0);
      chk("hold_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("hold_err", {31'd0, err}, 32'd0);
    end
    tx_valid = 1'b0;
    ss_n = 1'b1;
    step();
    chk("hold_release", {31'd0, busy}, 32'd0);
    chk("rx_data_held", {22'd0, rx_data}, 32'h0A5);

    // Read-data with tx_valid 2 cycles into RD_WAIT.
    send_frame(2'b11, 8'h00);
    chk("rd_rx_data", {22'd0, rx_data}, 32'h300);
    read_back(2, 8'h3C);

    // Read timeout.
    send_frame(2'b11, 8'h81);
    read_back(15, 8'h00);

    // Abort after 4 bits.
    ss_n = 1'b1; step();
    ss_n = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'($urandom);
      step();
    end
    ss_n = 1'b1;
    step();
    chk("abort_err", {31'd0, err}, 32'd1);
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    step();
    chk("abort_err_single", {31'd0, err}, 32'd0);
    chk("abort_rx_data_kept", {22'd0, rx_data}, 32'h381);
    send_frame(2'b01, 8'h5A);
    chk("post_abort_rx_data", {22'd0, rx_data}, 32'h15A);

    // Reset during TX bit 3.
    send_frame(2'b11, 8'hC6);
    tx_valid = 1'b1; tx_data = 8'hC6;
    step();
    tx_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("txrst_miso", {31'd0, miso}, 32'd0);
    chk("txrst_err", {31'd0, err}, 32'd0);
    chk("txrst_busy", {31'd0, busy}, 32'd0);
    chk("txrst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("txrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("txrst_no_restart", {31'd0, busy}, 32'd0);
      chk("txrst_no_err", {31'd0, err}, 32'd0);
    end

    // Randomized frames against the model.
    for (int n = 0; n < 16; n++) begin
      c  = 2'($urandom_range(0, 3));
      w  = 8'($urandom);
      td = 8'($urandom);
      d  = $urandom_range(0, 18);
      send_frame(c, w);
      chk("rnd_rx_data", {22'd0, rx_data}, {22'd0, c, w});
      if (c == 2'b11) begin
        read_back(d, td);
      end else begin
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("rnd_hold_miso", {31'd0, miso}, 32'd0);
        chk("rnd_hold_busy", {31'd0, busy}, 32'd1);
      end
      ss_n = 1'b1;
      step();
      chk("rnd_release", {31'd0, busy}, 32'd0);
    end

    // LSB-first, 12-bit word instance.
    send_frame_l(2'b01, 12'h9C3);
    send_frame_l(2'($urandom_range(0, 2)), 12'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
